// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU datapath blocks.
// Fetch-stage state encoding and the fetch buffer entry live here.
package cpu_pkg;

   localparam int N = 32;
   localparam int I = N / 2;

   localparam logic [N-1:0] RESET_PC = 32'h0000_0000;

   typedef enum logic {
      S_ISSUE = 1'b0,
      S_WAIT  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [N-1:0] inst;
      logic [N-1:0] pc4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch buffer kept as head/tail registers so the head output
// holds its last value once the buffer drains or is flushed.
module fetch_buf
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t head_q, head_d;
   fetch_entry_t tail_q, tail_d;
   logic [1:0]   count_q, count_d;
   logic         do_pop;
   logic         do_push;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      do_pop  = pop && (count_q != 2'd0);
      do_push = push && ((count_q != 2'd2) || do_pop);
      if (flush) begin
         count_d = 2'd0;
      end else begin
         unique case ({do_push, do_pop})
            2'b10: begin
               if (count_q == 2'd0) head_d = push_data;
               else                 tail_d = push_data;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               if (count_q == 2'd2) head_d = tail_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd2) begin
                  head_d = tail_q;
                  tail_d = push_data;
               end else begin
                  head_d = push_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign head  = head_q;
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight and
// buffers returned words for decode; branch/jump redirects retarget the PC.
//
// state   | meaning
// S_ISSUE | may issue a request when a buffer slot is free
// S_WAIT  | one request outstanding; drop_q marks its response stale
module fetch_unit
   import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   output logic          imem_req,
   output logic [N-1:0]  imem_addr,
   input  logic          imem_valid,
   input  logic [N-1:0]  imem_rdata,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [N-1:0]  inst_out,
   output logic [N-1:0]  pc4_out,
   input  logic          redirect_br,
   input  logic [N-1:0]  signimm,
   input  logic          redirect_j,
   input  logic [25:0]   jaddr,
   input  logic [N-1:0]  br_pc4
);

   fetch_state_t state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] req_pc_q, req_pc_d;
   logic         drop_q, drop_d;

   logic         redirect;
   logic         issue;
   logic [N-1:0] br_target;
   logic [N-1:0] j_target;
   logic [N-1:0] target;
   logic [N-1:0] req_pc4;

   logic         buf_push;
   logic         buf_pop;
   fetch_entry_t push_entry;
   fetch_entry_t head;
   logic [1:0]   count;

   assign redirect  = redirect_br | redirect_j;
   assign br_target = br_pc4 + (signimm << 2);
   assign j_target  = {br_pc4[N-1:28], jaddr, 2'b00};
   assign target    = redirect_br ? br_target : j_target;
   assign req_pc4   = req_pc_q + N'(4);
   assign issue     = (state_q == S_ISSUE) && (count < 2'd2) && !redirect;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_ISSUE;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         drop_q   <= drop_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      drop_d   = drop_q;
      buf_push = 1'b0;
      case (state_q)
         S_ISSUE: begin
            if (redirect) begin
               pc_d = target;
            end else if (issue) begin
               req_pc_d = pc_q;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_d = target;
               if (imem_valid) begin
                  drop_d  = 1'b0;
                  state_d = S_ISSUE;
               end else begin
                  drop_d  = 1'b1;
               end
            end else if (imem_valid) begin
               state_d = S_ISSUE;
               if (drop_q) begin
                  drop_d = 1'b0;
               end else begin
                  buf_push = 1'b1;
                  pc_d     = req_pc4;
               end
            end
         end
         default: state_d = S_ISSUE;
      endcase
   end

   // reset gates the strobe so nothing is requested while held in reset
   always_comb begin
      imem_req   = issue && !reset;
      imem_addr  = pc_q;
      inst_valid = (count != 2'd0);
      inst_out   = head.inst;
      pc4_out    = head.pc4;
      buf_pop    = inst_valid && inst_ready;
      push_entry = '{inst: imem_rdata, pc4: req_pc4};
   end

   fetch_buf u_fetch_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (buf_push),
      .push_data (push_entry),
      .pop       (buf_pop),
      .flush     (redirect),
      .head      (head),
      .count     (count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue model of the decode stream and an
// imem responder with random latency, directed scenarios then random traffic.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          imem_req;
   logic [31:0]   imem_addr;
   logic          imem_valid = 1'b0;
   logic [31:0]   imem_rdata = '0;
   logic          inst_valid;
   logic          inst_ready = 1'b0;
   logic [31:0]   inst_out;
   logic [31:0]   pc4_out;
   logic          redirect_br = 1'b0;
   logic [31:0]   signimm = '0;
   logic          redirect_j = 1'b0;
   logic [25:0]   jaddr = '0;
   logic [31:0]   br_pc4 = '0;

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_valid  (imem_valid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_out    (inst_out),
      .pc4_out     (pc4_out),
      .redirect_br (redirect_br),
      .signimm     (signimm),
      .redirect_j  (redirect_j),
      .jaddr       (jaddr),
      .br_pc4      (br_pc4)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // bench-side configuration (written by stimulus only)
   bit          const_mode = 1'b1;
   logic [31:0] const_word = 32'h2001_0005;
   int          r_dmin = 1;
   int          r_dmax = 1;
   bit          stray_en = 1'b0;

   // reference model / responder state (written by the model process only)
   fetch_entry_t sb[$];
   fetch_entry_t pop_log[$];
   logic [31:0]  req_log[$];
   bit           m_out = 1'b0;
   bit           m_stale = 1'b0;
   logic [31:0]  m_pc = RESET_PC;
   logic [31:0]  m_req_addr = '0;
   bit           r_pend = 1'b0;
   int           r_cnt = 0;
   logic [31:0]  r_addr = '0;
   bit           redir;
   bit           exp_req;
   logic [31:0]  tgt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] resp_data(input logic [31:0] a);
      return const_mode ? const_word : ((a * 32'h9E37_79B9) ^ 32'h5A5A_1234);
   endfunction

   // responder drives at +2 after the edge, model samples at +8
   always @(posedge clk) begin
      #2;
      imem_valid = 1'b0;
      if (r_pend) begin
         r_cnt--;
         if (r_cnt <= 0) begin
            imem_valid = 1'b1;
            imem_rdata = resp_data(r_addr);
            r_pend     = 1'b0;
         end
      end else if (stray_en && !m_out && ($urandom_range(99, 0) < 5)) begin
         imem_valid = 1'b1;
         imem_rdata = $urandom;
      end
      #6;
      if (reset) begin
         sb.delete();
         pop_log.delete();
         req_log.delete();
         m_out   = 1'b0;
         m_stale = 1'b0;
         m_pc    = RESET_PC;
         r_pend  = 1'b0;
      end else begin
         redir = redirect_br || redirect_j;
         if (redirect_br) tgt = br_pc4 + signimm * 32'd4;
         else             tgt = (br_pc4 & 32'hF000_0000) | ({6'd0, jaddr} * 32'd4);
         exp_req = !m_out && (sb.size() < 2) && !redir;
         check("inst_valid", {31'd0, inst_valid}, {31'd0, sb.size() != 0});
         check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
         if (imem_req && exp_req) check("imem_addr", imem_addr, m_pc);
         if (inst_valid && inst_ready && !redir && sb.size() != 0) begin
            check("inst_out", inst_out, sb[0].inst);
            check("pc4_out", pc4_out, sb[0].pc4);
            pop_log.push_back('{inst: inst_out, pc4: pc4_out});
            void'(sb.pop_front());
         end
         if (redir) begin
            sb.delete();
            m_pc = tgt;
            if (m_out && imem_valid) begin
               m_out   = 1'b0;
               m_stale = 1'b0;
            end else if (m_out) begin
               m_stale = 1'b1;
            end
         end else if (m_out && imem_valid) begin
            m_out = 1'b0;
            if (!m_stale) begin
               sb.push_back('{inst: resp_data(m_req_addr), pc4: m_req_addr + 32'd4});
               m_pc = m_req_addr + 32'd4;
            end
            m_stale = 1'b0;
         end
         if (exp_req) begin
            m_out      = 1'b1;
            m_stale    = 1'b0;
            m_req_addr = m_pc;
         end
         if (imem_req) begin
            req_log.push_back(imem_addr);
            r_pend = 1'b1;
            r_addr = imem_addr;
            r_cnt  = $urandom_range(r_dmax, r_dmin);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      redirect_br = 1'b0;
      redirect_j  = 1'b0;
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic pulse_redirect(input bit br, input bit j, input logic [31:0] pc4,
                                 input logic [31:0] imm, input logic [25:0] ja);
      redirect_br = br;
      redirect_j  = j;
      br_pc4      = pc4;
      signimm     = imm;
      jaddr       = ja;
      cyc(1);
      redirect_br = 1'b0;
      redirect_j  = 1'b0;
   endtask

   int k;

   initial begin
      #1;
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_imem_addr", imem_addr, RESET_PC);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_inst_out", inst_out, 32'd0);
      check("rst_pc4_out", pc4_out, 32'd0);
      cyc(2);
      reset = 1'b0;

      // sequential fetch, 1-cycle memory
      inst_ready = 1'b1;
      cyc(10);
      check("seq_n_req", req_log.size() >= 3, 32'd1);
      check("seq_addr0", req_log[0], 32'h0);
      check("seq_addr1", req_log[1], 32'h4);
      check("seq_addr2", req_log[2], 32'h8);
      check("seq_first_inst", pop_log[0].inst, 32'h2001_0005);
      check("seq_first_pc4", pop_log[0].pc4, 32'h4);

      // backpressure with stray responses while idle
      do_reset();
      inst_ready = 1'b0;
      stray_en   = 1'b1;
      cyc(15);
      check("bp_n_req", req_log.size(), 32'd2);
      check("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
      check("bp_imem_req", {31'd0, imem_req}, 32'd0);
      stray_en   = 1'b0;
      inst_ready = 1'b1;
      cyc(10);
      check("bp_resume_addr", req_log[2], 32'h8);
      check("bp_pop0_pc4", pop_log[0].pc4, 32'h4);
      check("bp_pop1_pc4", pop_log[1].pc4, 32'h8);

      // negative branch
      do_reset();
      inst_ready = 1'b0;
      cyc(6);
      k = req_log.size();
      pulse_redirect(1'b1, 1'b0, 32'h0000_0010, 32'hFFFF_8000, 26'h0);
      check("br_flush", {31'd0, inst_valid}, 32'd0);
      cyc(8);
      check("br_target", req_log[k], 32'hFFFE_0010);

      // jump, then branch+jump together
      inst_ready = 1'b1;
      k = req_log.size();
      pulse_redirect(1'b0, 1'b1, 32'h1000_0004, 32'h0, 26'h000_0040);
      cyc(8);
      check("j_target", req_log[k], 32'h1000_0100);
      k = req_log.size();
      pulse_redirect(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0001, 26'h000_0040);
      cyc(8);
      check("brj_target", req_log[k], 32'h0000_0014);

      // redirect while a slow response is pending
      do_reset();
      const_word = 32'hDEAD_BEEF;
      r_dmin = 4;
      r_dmax = 4;
      cyc(1);
      k = req_log.size();
      pulse_redirect(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0010, 26'h0);
      repeat (4) begin
         check("wait_drop_valid", {31'd0, inst_valid}, 32'd0);
         cyc(1);
      end
      cyc(3);
      check("wait_target", req_log[k], 32'h0000_0140);

      // async reset between edges with one buffered entry
      do_reset();
      const_word = 32'h2001_0005;
      r_dmin = 1;
      r_dmax = 1;
      inst_ready = 1'b0;
      cyc(3);
      check("ar_pre_valid", {31'd0, inst_valid}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check("ar_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("ar_imem_addr", imem_addr, RESET_PC);
      check("ar_imem_req", {31'd0, imem_req}, 32'd0);
      cyc(2);
      reset = 1'b0;

      // random traffic
      const_mode = 1'b0;
      r_dmin = 1;
      r_dmax = 3;
      stray_en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         automatic int r = $urandom_range(99, 0);
         automatic logic [15:0] imm16 = 16'($urandom);
         inst_ready  = ($urandom_range(9, 0) < 7);
         redirect_br = (r < 4);
         redirect_j  = (r >= 2) && (r < 7);
         br_pc4      = $urandom;
         signimm     = {{16{imm16[15]}}, imm16};
         jaddr       = 26'($urandom);
         cyc(1);
      end
      redirect_br = 1'b0;
      redirect_j  = 1'b0;
      stray_en    = 1'b0;
      cyc(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
